// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the command-driven up/down counter sequencer.
package cnt_seq_pkg;

  // Controller states; the encoding is visible in the status byte.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Command codes carried in ui_in[7:6].
  localparam logic [1:0] CMD_LOAD_CNT = 2'b00;
  localparam logic [1:0] CMD_LOAD_TC  = 2'b01;
  localparam logic [1:0] CMD_START    = 2'b10;
  localparam logic [1:0] CMD_STOP     = 2'b11;

  // Bit positions inside the status byte; bits [1:0] always read zero.
  localparam int ST_STATE_MSB = 7;
  localparam int ST_STATE_LSB = 6;
  localparam int ST_DONE_BIT  = 5;
  localparam int ST_WRAP_BIT  = 4;
  localparam int ST_DIR_BIT   = 3;
  localparam int ST_BUSY_BIT  = 2;

  // Assemble the status byte from the registered controller state.
  function automatic logic [7:0] pack_status(input state_e st,
                                             input logic   done_f,
                                             input logic   wrap_f,
                                             input logic   dir_f);
    logic [7:0] s;
    s = 8'h00;
    s[ST_STATE_MSB:ST_STATE_LSB] = st;
    s[ST_DONE_BIT]               = done_f;
    s[ST_WRAP_BIT]               = wrap_f;
    s[ST_DIR_BIT]                = dir_f;
    s[ST_BUSY_BIT]               = (st == ST_RUN) ? 1'b1 : 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/cnt_seq_sync.sv
// Two-flop synchronizer for the asynchronous command strobe, followed by a
// rising-edge detector that yields a single-cycle execute pulse.
module cnt_seq_sync
  import cnt_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_in,
  output logic rise_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next-state of the synchronizer chain and the edge-history flop.
  always_comb begin
    meta_d = strobe_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Chain registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // High for exactly one cycle after the synchronized strobe goes 0->1.
  assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command-driven 8-bit up/down counter with prescaler, terminal count and
// sticky done/wrap flags; uo_out shows either the count or a status byte.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int         PRE_W  = 3,
  parameter logic [7:0] RST_TC = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Input field decode; fields are only consumed in the execute cycle.
  logic [1:0]       cmd_s;
  logic             dir_in_s;
  logic             strobe_s;
  logic             view_s;
  logic [PRE_W-1:0] pre_in_s;
  logic             unused_s;

  assign cmd_s    = ui_in[7:6];
  assign dir_in_s = ui_in[5];
  assign strobe_s = ui_in[4];
  assign view_s   = ui_in[3];
  assign pre_in_s = PRE_W'(ui_in[2:0]);
  assign unused_s = ena;

  // Registered state.
  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       load_q, load_d;
  logic [7:0]       tc_q, tc_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic             go_s;
  logic             tick_s;
  logic             stop_s;
  logic             wrap_step_s;
  logic [7:0]       step_s;

  cnt_seq_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe_in  (strobe_s),
    .rise_pulse (go_s)
  );

  // Tick, step value and wrap detection derived from registered state.
  always_comb begin
    tick_s      = (state_q == ST_RUN) && (pcnt_q == pre_q);
    stop_s      = go_s && (cmd_s == CMD_STOP) && (state_q == ST_RUN);
    step_s      = dir_q ? (cnt_q - 8'd1) : (cnt_q + 8'd1);
    wrap_step_s = dir_q ? (cnt_q == 8'h00) : (cnt_q == 8'hFF);
  end

  // FSM next-state: command execution, then prescaled counting in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    tc_d    = tc_q;
    pcnt_d  = pcnt_q;
    pre_d   = pre_q;
    dir_d   = dir_q;
    done_d  = done_q;
    wrap_d  = wrap_q;

    if (go_s) begin
      case (cmd_s)
        CMD_LOAD_CNT: begin
          if (state_q != ST_RUN) begin
            load_d  = uio_in;
            cnt_d   = uio_in;
            state_d = ST_IDLE;
          end else begin
            load_d = load_q;
          end
        end
        CMD_LOAD_TC: begin
          tc_d = uio_in;
        end
        CMD_START: begin
          if (state_q != ST_RUN) begin
            dir_d   = dir_in_s;
            pre_d   = pre_in_s;
            done_d  = 1'b0;
            wrap_d  = 1'b0;
            pcnt_d  = {PRE_W{1'b0}};
            state_d = ST_RUN;
            // Restarting from DONE begins again at the last loaded value.
            cnt_d   = (state_q == ST_DONE) ? load_q : cnt_q;
          end else begin
            state_d = state_q;
          end
        end
        CMD_STOP: begin
          state_d = (state_q == ST_RUN) ? ST_IDLE : state_q;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // A STOP in the same edge as a tick wins: the count is held.
    if ((state_q == ST_RUN) && !stop_s) begin
      pcnt_d = tick_s ? {PRE_W{1'b0}} : (pcnt_q + {{(PRE_W-1){1'b0}}, 1'b1});
      if (tick_s) begin
        cnt_d  = step_s;
        wrap_d = wrap_q | wrap_step_s;
        if (step_s == tc_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          done_d = done_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      wrap_d = wrap_d;
    end
  end

  // State registers; reset overrides any command or tick in that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'h00;
      load_q  <= 8'h00;
      tc_q    <= RST_TC;
      pcnt_q  <= {PRE_W{1'b0}};
      pre_q   <= {PRE_W{1'b0}};
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      tc_q    <= tc_d;
      pcnt_q  <= pcnt_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // Zero-latency view mux over registered values; view is used unsynchronized.
  always_comb begin
    if (view_s) begin
      uo_out = pack_status(state_q, done_q, wrap_q, dir_q);
    end else begin
      uo_out = cnt_q;
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Scoreboard bench for cnt_seq_ctrl: stimulus queues expected uo_out values,
// a negedge monitor pops and compares them.
module tb_cnt_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  localparam logic [1:0] C_LCNT  = 2'b00;
  localparam logic [1:0] C_LTC   = 2'b01;
  localparam logic [1:0] C_START = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  int checks;
  int failures;

  string      name_q[$];
  logic [7:0] exp_q[$];

  cnt_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the queued expectation against uo_out mid-cycle.
  always @(negedge clk) begin
    string      nm;
    logic [7:0] ex;
    if (exp_q.size() > 0) begin
      nm = name_q.pop_front();
      ex = exp_q.pop_front();
      checks++;
      if (uo_out !== ex) begin
        failures++;
        $display("FAIL %s: uo_out=%02h expected=%02h", nm, uo_out, ex);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Select the view and queue the value uo_out must show this cycle.
  task automatic expect_out(input string nm, input logic v, input logic [7:0] ex);
    ui_in[3] = v;
    name_q.push_back(nm);
    exp_q.push_back(ex);
  endtask

  // One strobe-low cycle, then strobe high; returns just after the execute edge.
  task automatic send_cmd(input logic [1:0] c, input logic d, input logic [2:0] p,
                          input logic [7:0] data);
    ui_in[7:6] = c;
    ui_in[5]   = d;
    ui_in[2:0] = p;
    ui_in[4]   = 1'b0;
    uio_in     = data;
    step();
    ui_in[4] = 1'b1;
    step();
    step();
    step();
    ui_in[4] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    expect_out("rst_cnt", 1'b0, 8'h00);
    step();
    expect_out("rst_status", 1'b1, 8'h00);
    step();

    // Load and count up one per cycle; then STOP mid-run.
    send_cmd(C_LCNT, 1'b0, 3'd0, 8'h10);
    expect_out("load_cnt", 1'b0, 8'h10);
    send_cmd(C_START, 1'b0, 3'd0, 8'h00);
    expect_out("start_cnt", 1'b0, 8'h10);
    step(); expect_out("up_11", 1'b0, 8'h11);
    step(); expect_out("up_12", 1'b0, 8'h12);
    step(); expect_out("up_13", 1'b0, 8'h13);
    send_cmd(C_STOP, 1'b0, 3'd0, 8'h00);
    expect_out("stop_cnt", 1'b0, 8'h16);
    step(); expect_out("stop_hold", 1'b0, 8'h16);
    step(); expect_out("stop_status", 1'b1, 8'h00);
    step();

    // Terminal count reached after four ticks; restart from DONE reloads.
    send_cmd(C_LTC, 1'b0, 3'd0, 8'h14);
    send_cmd(C_LCNT, 1'b0, 3'd0, 8'h10);
    send_cmd(C_START, 1'b0, 3'd0, 8'h00);
    step(); step(); step();
    expect_out("tc_13", 1'b0, 8'h13);
    step(); expect_out("tc_hit", 1'b0, 8'h14);
    step(); expect_out("tc_frozen", 1'b0, 8'h14);
    step(); expect_out("done_status", 1'b1, 8'hA0);
    send_cmd(C_START, 1'b0, 3'd0, 8'h00);
    expect_out("restart_status", 1'b1, 8'h44);
    step(); expect_out("restart_cnt", 1'b0, 8'h11);
    step(); step(); step();

    // LOAD_CNT in DONE returns to IDLE; done flag stays sticky.
    send_cmd(C_LCNT, 1'b0, 3'd0, 8'h01);
    expect_out("done_to_idle", 1'b1, 8'h20);
    step(); expect_out("load_01", 1'b0, 8'h01);

    // Count down through the wrap to terminal count F0.
    send_cmd(C_LTC, 1'b0, 3'd0, 8'hF0);
    send_cmd(C_START, 1'b1, 3'd0, 8'h00);
    expect_out("down_status", 1'b1, 8'h4C);
    step(); expect_out("down_00", 1'b0, 8'h00);
    step(); expect_out("down_ff", 1'b0, 8'hFF);
    step(); expect_out("wrap_status", 1'b1, 8'h5C);
    for (int i = 0; i < 14; i++) step();
    expect_out("down_f0", 1'b0, 8'hF0);
    step(); expect_out("down_done", 1'b1, 8'hB8);
    step(); expect_out("down_frozen", 1'b0, 8'hF0);

    // Prescale 3: one step every four cycles.
    send_cmd(C_LCNT, 1'b0, 3'd0, 8'h00);
    send_cmd(C_START, 1'b0, 3'd3, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step();
      expect_out("pre3", 1'b0, 8'(i / 4));
    end

    // LOAD_CNT while running is ignored; STOP coinciding with a tick holds.
    send_cmd(C_LCNT, 1'b0, 3'd3, 8'h55);
    expect_out("load_in_run", 1'b0, 8'h03);
    send_cmd(C_STOP, 1'b0, 3'd3, 8'h00);
    expect_out("stop_on_tick", 1'b0, 8'h03);
    step(); expect_out("stop3_status", 1'b1, 8'h00);
    step(); expect_out("stop3_hold", 1'b0, 8'h03);

    // START with count already at terminal count runs a full 256 steps.
    send_cmd(C_LTC, 1'b0, 3'd0, 8'h20);
    send_cmd(C_LCNT, 1'b0, 3'd0, 8'h20);
    send_cmd(C_START, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 255; i++) step();
    expect_out("full_run_status", 1'b1, 8'h54);
    step(); expect_out("full_run_cnt", 1'b0, 8'h20);
    step(); expect_out("full_run_done", 1'b1, 8'hB0);

    // Reset mid-run aborts; default terminal count FF takes effect again.
    send_cmd(C_LCNT, 1'b0, 3'd0, 8'hFD);
    send_cmd(C_START, 1'b0, 3'd0, 8'h00);
    step(); expect_out("pre_rst_cnt", 1'b0, 8'hFE);
    rst_n = 1'b0;
    step(); expect_out("rst_mid_cnt", 1'b0, 8'h00);
    rst_n = 1'b1;
    step(); expect_out("rst_mid_status", 1'b1, 8'h00);
    send_cmd(C_LCNT, 1'b0, 3'd0, 8'hFD);
    send_cmd(C_START, 1'b0, 3'd0, 8'h00);
    step(); step();
    expect_out("tc_default_cnt", 1'b0, 8'hFF);
    step(); expect_out("tc_default_done", 1'b1, 8'hA0);

    step();
    step();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
